value_loader: RTL and testbench
===============================

Name: value_loader

Overview:
- Writer-side feeder for the lattice value pipeline.
- Accepts node values one word per handshake and packs them into a LANES-wide parallel vector, lane 0 first.
- Presents the completed vector to the per-cycle value buffer array with a valid/ready handshake.
- Supplies both the initial leaf payoffs and refill chunks, so downstream lanes see ordered, contiguous node values.

Parameters:
- WIDTH, 64: bits per node value.
- LANES, 32: node values per output vector.
- IDX_W, 5: lane index width; must satisfy 2**IDX_W >= LANES.
- CHUNK_W, 16: width of the emitted-vector counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  WIDTH  node value.
- in_last  input  1  final word of the current tree level; closes the vector early.
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  consumer takes the vector this cycle.
- out_data  output  WIDTH*LANES  lane k at bits [k*WIDTH +: WIDTH].
- out_last  output  1  vector was closed by in_last.
- out_fill  output  IDX_W+1  number of real, non-padded lanes in out_data (1..LANES).
- chunk_count  output  CHUNK_W  vectors handed off since reset; wraps modulo 2**CHUNK_W.

Behaviour:
- Reset (asynchronous, reset_n low) clears state to FILL, lane index to 0, out_data to 0, out_valid, out_last, out_fill and chunk_count to 0. in_ready is 1 after reset release.
- Reset asserted mid-operation discards any partial or held vector; no handshake completes in that cycle.
- State FILL:
  - in_ready = 1.
  - On in_valid: lane[idx] <= in_data and idx increments.
  - If idx == LANES-1 or in_last = 1, go to HOLD next cycle with out_valid = 1, out_fill = idx+1, out_last = in_last.
  - Lanes above idx are padded with 0 (see Optional Feature).
- State HOLD:
  - in_ready = 0 and out_data is stable.
  - On out_ready: out_valid <= 0, chunk_count increments, idx <= 0, next state FILL, and lanes are cleared to 0.
- Latency: out_valid rises the cycle after the closing word is accepted. The minimum vector period is fill words + 1 handoff cycle.
- in_last on the word that fills lane LANES-1: single close, out_last = 1, out_fill = LANES.
- in_valid while in HOLD: ignored, no capture. The producer must hold its word until in_ready.
- out_ready while in FILL: ignored.
- out_valid never drops without an out_ready handshake.
- chunk_count at all-ones wraps to 0 on the next handshake.
- The FSM has two states only (FILL, HOLD). An unreachable encoding recovers to FILL.

Optional Feature:
- Macro: VALUE_LOADER_PAD_HOLD_EN.
- Defined: lanes above the last real lane replicate the final accepted word. This gives the boundary node a valid upper neighbour.
- Undefined: padding lanes are 0.
- out_fill is identical in both builds.

Test Plan:
- Reset release, stream words 1..32 with in_valid held high and out_ready=0:
  - Expect in_ready low after the 32nd accept.
  - Expect out_valid=1, lane k = k+1, out_fill=32, out_last=0.
  - Pulse out_ready: expect chunk_count=1 and in_ready=1 the next cycle.
- Send 5 words 0xA..0xE with in_last on the 5th:
  - Expect out_fill=5, out_last=1, lanes 0..4 = 0xA..0xE.
  - Lanes 5..31 = 0, or = 0xE with VALUE_LOADER_PAD_HOLD_EN.
- In HOLD, drive in_valid=1 with in_data=0xDEAD for 10 cycles:
  - Expect out_data unchanged and no lane holding 0xDEAD.
  - After out_ready, the next vector's lane 0 equals the first word presented after the handshake.
- Random in_valid gaps (about 50%) over 4 full vectors of incrementing data:
  - Expect contiguous values across vectors; vector n lane 0 = 32n+1.
  - Expect chunk_count=4 at the end.
- Assert reset_n low after 17 words accepted:
  - Expect out_valid=0 and out_data=0 immediately (asynchronous).
  - After release, 32 new words produce a vector with none of the old data.
- Force chunk_count to 0xFFFF via 65535 short vectors (in_last on every word):
  - Next handshake gives chunk_count=0, each vector has out_fill=1.

Source files
------------

// File: rtl/value_loader.sv
// value_loader: packs node values into a LANES-wide vector, lane 0 first, and hands it off over valid/ready.
// Define VALUE_LOADER_PAD_HOLD_EN to pad the unused upper lanes with the last accepted word instead of 0.
module value_loader #(
  parameter int WIDTH   = 64,
  parameter int LANES   = 32,
  parameter int IDX_W   = 5,
  parameter int CHUNK_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic                   out_last,
  output logic [IDX_W:0]         out_fill,
  output logic [CHUNK_W-1:0]     chunk_count
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic accept, close, take;
  assign in_ready  = state == FILL;
  assign out_valid = state == HOLD;
  always_comb begin
    accept    = state == FILL && in_valid;
    close     = accept && (idx == IDX_W'(LANES - 1) || in_last);
    take      = state == HOLD && out_ready;
    state_nxt = state == HOLD ? (take ? FILL : HOLD) : (close ? HOLD : FILL);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= FILL;
      idx         <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_fill    <= '0;
      chunk_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data[idx*WIDTH +: WIDTH] <= in_data;
        idx <= idx + 1'b1;
      end
`ifdef VALUE_LOADER_PAD_HOLD_EN
      // Give the boundary node a valid upper neighbour.
      if (close)
        for (int k = 0; k < LANES; k++)
          if (k > int'(idx)) out_data[k*WIDTH +: WIDTH] <= in_data;
`endif
      if (close) begin
        out_fill <= (IDX_W+1)'(idx) + 1'b1;
        out_last <= in_last;
      end
      // Lanes are zeroed on handoff so default padding comes for free.
      if (take) begin
        idx         <= '0;
        out_data    <= '0;
        chunk_count <= chunk_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_value_loader.sv
// tb_value_loader: directed, table-driven bench for value_loader.
// The DUT uses an 8-bit chunk counter so the wrap corner is reachable in a short run.
module tb_value_loader;
  localparam int W = 64, L = 32, IW = 5, CW = 8;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [W*L-1:0] out_data;
  logic [IW:0] out_fill;
  logic [CW-1:0] chunk_count;
  logic [CW-1:0] exp_chunk = '0;
  int n_chk = 0, n_fail = 0;

  value_loader #(.WIDTH(W), .LANES(L), .IDX_W(IW), .CHUNK_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_fill(out_fill), .chunk_count(chunk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] base;
    int           n;
    logic         last;
    int           fill;
    logic         elast;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_lane(input logic [W-1:0] base, input int n, input int k);
    if (k < n) return base + W'(k);
`ifdef VALUE_LOADER_PAD_HOLD_EN
    return base + W'(n - 1);
`else
    return '0;
`endif
  endfunction

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int t = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_vec(input logic [W-1:0] base, input int n, input logic l);
    for (int i = 0; i < n; i++) send_word(base + W'(i), l && i == n - 1);
  endtask

  task automatic check_vec(input logic [W-1:0] base, input int n, input int fill, input logic elast);
    chk("out_valid", out_valid, 1);
    chk("out_fill", out_fill, W'(fill));
    chk("out_last", out_last, elast);
    for (int k = 0; k < L; k++) chk($sformatf("lane%0d", k), out_data[k*W +: W], exp_lane(base, n, k));
  endtask

  task automatic handshake;
    chk("hs_valid", out_valid, 1);
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    exp_chunk++;
    chk("hs_drop", out_valid, 0);
    chk("hs_ready", in_ready, 1);
    chk("chunk", chunk_count, exp_chunk);
  endtask

  initial begin
    vecs[0] = '{64'hA,   5,  1'b1, 5,  1'b1};
    vecs[1] = '{64'h100, 32, 1'b1, 32, 1'b1};
    vecs[2] = '{64'h200, 1,  1'b1, 1,  1'b1};
    vecs[3] = '{64'h300, 32, 1'b0, 32, 1'b0};
    vecs[4] = '{64'h400, 31, 1'b1, 31, 1'b1};

    repeat (2) @(posedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", W'(out_data != 0), 0);
    chk("rst_fill", out_fill, 0);
    chk("rst_last", out_last, 0);
    chk("rst_chunk", chunk_count, 0);
    reset_n = 1; #1;
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;

    // Full vector, in_valid held high
    send_vec(1, 31, 0);
    chk("no_early_valid", out_valid, 0);
    send_word(32, 0);
    chk("ready_low_full", in_ready, 0);
    check_vec(1, 32, 32, 0);
    handshake();

    // Table of vector shapes
    for (int v = 0; v < 5; v++) begin
      send_vec(vecs[v].base, vecs[v].n, vecs[v].last);
      check_vec(vecs[v].base, vecs[v].n, vecs[v].fill, vecs[v].elast);
      handshake();
    end

    // out_ready while filling is ignored
    out_ready = 1; repeat (3) @(posedge clk); #1; out_ready = 0;
    chk("fill_ready_chunk", chunk_count, exp_chunk);
    chk("fill_ready_valid", out_valid, 0);

    // Words offered during HOLD are not captured
    send_vec(64'h50, 3, 1);
    in_valid = 1; in_data = 64'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    check_vec(64'h50, 3, 3, 1);
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
    exp_chunk++;
    chk("hold_hs_chunk", chunk_count, exp_chunk);
    in_data = 64'h77; in_last = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    check_vec(64'h77, 1, 1, 1);
    handshake();

    // Asynchronous reset mid-fill
    send_vec(64'h900, 17, 0);
    #2 reset_n = 0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", W'(out_data != 0), 0);
    chk("arst_chunk", chunk_count, 0);
    exp_chunk = '0;
    #1 reset_n = 1;
    @(posedge clk); #1;
    send_vec(64'h1000, 32, 0);
    check_vec(64'h1000, 32, 32, 0);
    handshake();
    exp_chunk = '0;
    reset_n = 0; #1 reset_n = 1;
    @(posedge clk); #1;

    // Random input gaps over four contiguous vectors
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < L; i++) begin
        repeat ($urandom_range(0, 1)) @(posedge clk);
        #1 send_word(W'(32 * n + i + 1), 0);
      end
      check_vec(W'(32 * n + 1), 32, 32, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 handshake();
    end
    chk("gap_chunk4", chunk_count, 4);

    // Chunk counter wrap via single-word vectors
    while (exp_chunk != '1) begin
      send_word(W'(exp_chunk), 1);
      chk("short_fill", out_fill, 1);
      handshake();
    end
    chk("chunk_full", chunk_count, W'(2**CW - 1));
    send_word(64'h5, 1);
    chk("wrap_fill", out_fill, 1);
    handshake();
    chk("chunk_wrap", chunk_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
